// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and sizing helpers for ram_arbiter_rr.
package ram_arb_pkg;

    // IDLE: nothing issued last cycle; RD/WR: a read/write was issued last cycle.
    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_e;

    localparam int unsigned MAX_REQ = 8;

    // Round-robin pointer width, $clog2(num_req), never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_rr_pick.sv
// rr_pick: combinational one-hot winner among asserted requests.
// Round-robin search starts at ptr and wraps; with RAM_ARB_FIXED_PRIO_EN
// defined the lowest asserted index wins and ptr is ignored.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh
);

    // First pass covers indices at or above ptr, second pass wraps to the bottom.
    always_comb begin
        logic found;
        win_oh = '0;
        found  = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: shares one single-port synchronous RAM (registered read,
// cs/we/oe control) between NUM_REQ requesters, one access per cycle, with a
// one-cycle bubble before a write that follows a read (oe is gated by ~we).
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no pointer register); default build is round-robin.
module ram_arbiter_rr
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           ram_cs,
    output logic                           ram_we,
    output logic                           ram_oe,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("ram_arbiter_rr: unsupported NUM_REQ/DEPTH/ADDR_WIDTH combination");
    end

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      win_oh;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    bubble;
    logic                    grant;

    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      ret_q, ret_d;
    logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ram_cs_q, ram_cs_d;
    logic                    ram_we_q, ram_we_d;
    logic                    ram_oe_q, ram_oe_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        sel_next;
    assign ptr = ptr_q;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .win_oh (win_oh)
    );

    // Mux the winner's request fields (and its successor index) out of the packed buses.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        sel_next  = '0;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
`ifndef RAM_ARB_FIXED_PRIO_EN
                sel_next  = (i + 1 == NUM_REQ) ? '0 : PTR_W'(i + 1);
`endif
            end
        end
    end

    // Next-state, grant and RAM pin decode; a write winner right after a read becomes a bubble.
    always_comb begin
        bubble      = (state_q == RD) && (|win_oh) && sel_we;
        grant       = (|win_oh) && !bubble;
        state_d     = IDLE;
        if (grant) begin
            state_d = sel_we ? WR : RD;
        end
        gnt_d       = grant ? win_oh : '0;
        ram_cs_d    = grant || (state_q == RD);
        ram_we_d    = grant && sel_we;
        ram_oe_d    = (state_q == RD);
        ram_addr_d  = grant ? sel_addr : ram_addr_q;
        ram_wdata_d = grant ? sel_wdata : ram_wdata_q;
        // gnt_q in RD state is the read just issued; it moves one stage per edge to rvalid.
        ret_d       = (state_q == RD) ? gnt_q : '0;
        rvalid_d    = ret_q;
        rdata_d     = (|ret_q) ? ram_rdata : rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        ptr_d       = grant ? sel_next : ptr_q;
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ret_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ret_q       <= ret_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// tb_ram_arbiter_rr: directed scenarios plus randomized traffic for
// ram_arbiter_rr, with a behavioural RAM and a transaction-level reference.
// Build option: RAM_ARB_FIXED_PRIO_EN swaps the contention scenario for the
// fixed-priority one and switches the reference to lowest-index-wins.
module tb_ram_arbiter_rr;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned AWT        = NUM_REQ * ADDR_WIDTH;
    localparam int unsigned DWT        = NUM_REQ * DATA_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_we;
    logic [AWT-1:0]         req_addr;
    logic [DWT-1:0]         req_wdata;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     rvalid;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   ram_cs;
    logic                   ram_we;
    logic                   ram_oe;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter_rr #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Behavioural single-port RAM: registered read, output driven only while oe.
    logic [DATA_WIDTH-1:0] ram_mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_dout;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end
    assign ram_rdata = ram_oe ? ram_dout : '0;

    // Reference: arbitration by rule, memory contents as an array, read returns as a timed queue.
    typedef struct {
        int unsigned           due;
        int unsigned           idx;
        logic [DATA_WIDTH-1:0] data;
    } ret_t;

    ret_t                   rq[$];
    logic [DATA_WIDTH-1:0]  ref_mem [DEPTH];
    int unsigned            cyc = 0;
    int unsigned            m_ptr = 0;
    bit                     m_last_rd = 0;
    int unsigned            m_w, m_c;
    bit                     m_found;
    logic [NUM_REQ-1:0]     exp_gnt = '0;
    logic [NUM_REQ-1:0]     exp_rvalid = '0;
    logic [DATA_WIDTH-1:0]  exp_rdata = '0;
    logic                   exp_cs = 1'b0, exp_we = 1'b0, exp_oe = 1'b0;
    logic [ADDR_WIDTH-1:0]  exp_addr = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 0; m_last_rd = 0; rq.delete();
            exp_gnt = '0; exp_rvalid = '0; exp_rdata = '0;
            exp_cs = 1'b0; exp_we = 1'b0; exp_oe = 1'b0; exp_addr = '0;
        end else begin
            cyc++;
            exp_rvalid = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                exp_rvalid = NUM_REQ'(1) << rq[0].idx;
                exp_rdata  = rq[0].data;
                void'(rq.pop_front());
            end
            m_found = 0; m_w = 0;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                m_c = k;
`else
                m_c = (m_ptr + k) % NUM_REQ;
`endif
                if (!m_found && ((req >> m_c) & NUM_REQ'(1)) != '0) begin
                    m_found = 1; m_w = m_c;
                end
            end
            exp_oe  = m_last_rd;
            exp_gnt = '0;
            exp_we  = 1'b0;
            if (m_found && !(m_last_rd && ((req_we >> m_w) & NUM_REQ'(1)) != '0)) begin
                exp_gnt  = NUM_REQ'(1) << m_w;
                m_ptr    = (m_w + 1) % NUM_REQ;
                exp_addr = ADDR_WIDTH'(req_addr >> (m_w * ADDR_WIDTH));
                if (((req_we >> m_w) & NUM_REQ'(1)) != '0) begin
                    ref_mem[exp_addr] = DATA_WIDTH'(req_wdata >> (m_w * DATA_WIDTH));
                    exp_we    = 1'b1;
                    m_last_rd = 0;
                end else begin
                    rq.push_back('{cyc + 2, m_w, ref_mem[exp_addr]});
                    m_last_rd = 1;
                end
            end else begin
                m_last_rd = 0;
            end
            exp_cs = (exp_gnt != '0) || exp_oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input bit on, input bit we,
                           input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        req       = (req & ~(NUM_REQ'(1) << i)) | (NUM_REQ'(on) << i);
        req_we    = (req_we & ~(NUM_REQ'(1) << i)) | (NUM_REQ'(we) << i);
        req_addr  = (req_addr & ~(AWT'({ADDR_WIDTH{1'b1}}) << (i * ADDR_WIDTH))) | (AWT'(a) << (i * ADDR_WIDTH));
        req_wdata = (req_wdata & ~(DWT'({DATA_WIDTH{1'b1}}) << (i * DATA_WIDTH))) | (DWT'(d) << (i * DATA_WIDTH));
    endtask

    task automatic drain();
        req = '0;
        repeat (3) tick();
    endtask

    task automatic pulse_reset();
        req = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) tick();
        checks++;
        if ({gnt, rvalid, rdata, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h cs=%b we=%b oe=%b addr=%h wdata=%h, want all zero",
                     gnt, rvalid, rdata, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        set_req(0, 1, 1, 4'd3, 32'hDEADBEEF);
        tick();
        checks++;
        if ({gnt, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata} !== {2'b01, 3'b110, 4'd3, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL wr_grant: got gnt=%b cs=%b we=%b oe=%b addr=%h wdata=%h, want 01 1 1 0 3 deadbeef",
                     gnt, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata);
        end
        req = '0;
        tick();
        set_req(0, 1, 0, 4'd3, 32'h0);
        tick();
        checks++;
        if ({gnt, ram_cs, ram_we, ram_addr} !== {2'b01, 2'b10, 4'd3}) begin
            errors++;
            $display("FAIL rd_grant: got gnt=%b cs=%b we=%b addr=%h, want 01 1 0 3", gnt, ram_cs, ram_we, ram_addr);
        end
        req = '0;
        tick();
        checks++;
        if ({rvalid, ram_cs, ram_we, ram_oe} !== {2'b00, 3'b101}) begin
            errors++;
            $display("FAIL rd_return_cycle: got rvalid=%b cs=%b we=%b oe=%b, want 00 1 0 1", rvalid, ram_cs, ram_we, ram_oe);
        end
        tick();
        checks++;
        if (rvalid !== 2'b01 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: got rvalid=%b rdata=%h, want 01 deadbeef", rvalid, rdata);
        end
        drain();
    endtask

    task automatic test_contention();
        pulse_reset();
        set_req(0, 1, 0, 4'd1, 32'h0);
        set_req(1, 1, 0, 4'd2, 32'h0);
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (gnt !== (NUM_REQ'(1) << (k % 2))) begin
                errors++;
                $display("FAIL contention_order[%0d]: got gnt=%b want %b", k, gnt, NUM_REQ'(1) << (k % 2));
            end
        end
        drain();
    endtask

`ifdef RAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        pulse_reset();
        set_req(0, 1, 0, 4'd1, 32'h0);
        set_req(1, 1, 0, 4'd2, 32'h0);
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (gnt !== 2'b01) begin
                errors++;
                $display("FAIL fixed_prio_hold[%0d]: got gnt=%b want 01", k, gnt);
            end
        end
        set_req(0, 0, 0, 4'd0, 32'h0);
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL fixed_prio_release: got gnt=%b want 10", gnt);
        end
        drain();
    endtask
`endif

    task automatic test_turnaround();
        pulse_reset();
        set_req(1, 1, 0, 4'd5, 32'h0);
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL ta_read_grant: got gnt=%b want 10", gnt);
        end
        set_req(1, 0, 0, 4'd0, 32'h0);
        set_req(0, 1, 1, 4'd6, 32'h600D_F00D);
        tick();
        checks++;
        if ({gnt, ram_cs, ram_we, ram_oe} !== {2'b00, 3'b101}) begin
            errors++;
            $display("FAIL ta_bubble: got gnt=%b cs=%b we=%b oe=%b, want 00 1 0 1", gnt, ram_cs, ram_we, ram_oe);
        end
        tick();
        checks++;
        if ({gnt, ram_we, ram_oe, rvalid} !== {2'b01, 2'b10, 2'b10}) begin
            errors++;
            $display("FAIL ta_write_grant: got gnt=%b we=%b oe=%b rvalid=%b, want 01 1 0 10", gnt, ram_we, ram_oe, rvalid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int unsigned a = 1; a <= 3; a++) begin
            set_req(1, 1, 1, ADDR_WIDTH'(a), 32'hC0DE_0000 | a);
            tick();
            checks++;
            if (gnt !== 2'b10 || ram_we !== 1'b1) begin
                errors++;
                $display("FAIL b2b_write[%0d]: got gnt=%b we=%b want 10 1", a, gnt, ram_we);
            end
        end
        for (int unsigned k = 0; k < 6; k++) begin
            if (k < 3) set_req(1, 1, 0, ADDR_WIDTH'(k + 1), 32'h0);
            else       req = '0;
            tick();
            checks++;
            if (gnt !== ((k < 3) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: got %b want %b", k, gnt, (k < 3) ? 2'b10 : 2'b00);
            end
            checks++;
            if (rvalid !== ((k >= 2 && k < 5) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, rvalid, (k >= 2 && k < 5) ? 2'b10 : 2'b00);
            end
            if (k >= 2 && k < 5) begin
                checks++;
                if (rdata !== (32'hC0DE_0000 | (k - 1))) begin
                    errors++;
                    $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, 32'hC0DE_0000 | (k - 1));
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_read();
        set_req(1, 1, 0, 4'd3, 32'h0);
        tick();
        req = '0; rst = 1'b1;
        tick();
        checks++;
        if ({gnt, rvalid, rdata, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got gnt=%b rvalid=%b rdata=%h cs=%b we=%b oe=%b addr=%h, want all zero",
                     gnt, rvalid, rdata, ram_cs, ram_we, ram_oe, ram_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rvalid !== 2'b00 || ram_oe !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_return: got rvalid=%b oe=%b want 00 0", rvalid, ram_oe);
        end
        set_req(0, 1, 0, 4'd7, 32'h0);
        set_req(1, 1, 0, 4'd8, 32'h0);
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL midrst_first_grant: got gnt=%b want 01", gnt);
        end
        drain();
    endtask

    task automatic test_random();
        for (int unsigned a = 0; a < DEPTH; a++) begin
            set_req(0, 1, 1, ADDR_WIDTH'(a), $urandom);
            tick();
        end
        drain();
        for (int unsigned n = 0; n < 400; n++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (((req >> i) & NUM_REQ'(1)) == '0 || ((gnt >> i) & NUM_REQ'(1)) != '0)
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                            ADDR_WIDTH'($urandom_range(0, DEPTH - 1)), $urandom);
            end
            tick();
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL rnd_gnt @%0d: got %b want %b", n, gnt, exp_gnt);
            end
            checks++;
            if (rvalid !== exp_rvalid) begin
                errors++;
                $display("FAIL rnd_rvalid @%0d: got %b want %b", n, rvalid, exp_rvalid);
            end
            if (exp_rvalid != '0) begin
                checks++;
                if (rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL rnd_rdata @%0d: got %h want %h", n, rdata, exp_rdata);
                end
            end
            checks++;
            if ({ram_cs, ram_we, ram_oe} !== {exp_cs, exp_we, exp_oe}) begin
                errors++;
                $display("FAIL rnd_ctrl @%0d: got cs/we/oe=%b%b%b want %b%b%b", n, ram_cs, ram_we, ram_oe, exp_cs, exp_we, exp_oe);
            end
            if (exp_gnt != '0) begin
                checks++;
                if (ram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL rnd_addr @%0d: got %h want %h", n, ram_addr, exp_addr);
                end
            end
            checks++;
            if ((ram_we & ram_oe) !== 1'b0) begin
                errors++;
                $display("FAIL rnd_we_oe_overlap @%0d: got we=%b oe=%b want not both", n, ram_we, ram_oe);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_write_read();
`ifdef RAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
`endif
        test_turnaround();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter_rr.md
Name: ram_arbiter_rr

Overview:
- Shares one single-port synchronous RAM (registered read, cs/we/oe control) between NUM_REQ requesters.
- Round-robin arbitration with one access issued per cycle.
- Enforces a one-cycle read-to-write bus turnaround, because the RAM output enable is gated by ~we.
- Sits between client blocks and the RAM instance; it is the only driver of the RAM control pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 4, RAM address width
- DEPTH, 16, RAM depth; addresses >= DEPTH are not checked by this block

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester access request, level
- req_we  in  NUM_REQ  1 = write, 0 = read; valid with req
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- gnt  out  NUM_REQ  one-hot grant pulse, registered
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse
- rdata  out  DATA_WIDTH  read data, shared by all requesters; qualified by rvalid
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data; sampled only in return cycles

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: gnt=0, rvalid=0, rdata=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, ram_wdata=0; state=IDLE; rr pointer=0.
- Arbitration:
  - At each edge, the arbiter picks a winner among asserted req.
  - The search starts at the rr pointer and wraps modulo NUM_REQ.
  - On grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
- Grant (edge E1):
  - gnt[i]=1 for exactly one cycle.
  - ram_cs=1; ram_we=req_we[i]; ram_addr and ram_wdata are registered from slice i.
- Requester handshake:
  - During the cycle where gnt[i]=1, the requester drops req or presents its next request.
  - A req still high at the next edge is a new access.
  - req, req_we, req_addr and req_wdata must be stable while req=1 and gnt=0.
- Read timing:
  - The RAM captures data at E2.
  - In the cycle after E2: ram_oe=1, ram_cs=1, ram_we=0 (the return cycle).
  - At E3: rdata<=ram_rdata and rvalid[i]=1 for one cycle.
  - Latency from grant edge to rvalid is 2 cycles.
  - Back-to-back reads give full throughput.
- FSM states:
  - IDLE: no access issued last cycle.
  - RD: read issued last cycle.
  - WR: write issued last cycle.
  - Transitions: any state -> RD/WR on a read/write grant; -> IDLE when no grant.
- Turnaround:
  - In RD, if the rr winner is a write, no grant is issued (bubble) and the pointer is unchanged.
  - Next state is IDLE; the write is granted on the following edge.
  - A read winner in RD is granted normally.
  - ram_we is never 1 in a cycle where ram_oe=1.
- Simultaneous requests: only one gnt per cycle; losers wait. Maximum wait is NUM_REQ-1 grants plus one bubble.
- No requests: ram_cs=0 unless in a read-return cycle.
- Reset mid-operation:
  - Outstanding read returns are dropped (no rvalid).
  - The pointer returns to 0 and ram_cs/ram_oe drop at the reset edge.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is not implemented. The turnaround bubble still applies.
- Undefined: round-robin as above.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, RD, WR}
  - localparam for the pointer width, $clog2(NUM_REQ)
- Sub-module rr_pick:
  - Combinational one-hot winner from req and pointer.
  - Covers the RAM_ARB_FIXED_PRIO_EN variant.

Test Plan:
- Single write then read: req[0] write addr=3 data=0xDEADBEEF; then req[0] read addr=3 -> gnt[0] each time; rvalid[0] 2 cycles after read grant; rdata=0xDEADBEEF.
- Contention: req[0] and req[1] reads held for 4 grants, pointer=0 -> grant order 0,1,0,1; exactly one gnt per cycle.
- Turnaround: req[1] read granted, then req[0] write pending -> one bubble cycle (ram_cs=0 only if no return, ram_we=0 while ram_oe=1); write granted the next cycle.
- Back-to-back reads to addrs 1,2,3 from req[1] -> gnt on 3 consecutive cycles; rvalid[1] on 3 consecutive cycles with matching data.
- Reset mid-read: assert rst the cycle after a read grant -> no rvalid; all outputs 0; the next grant goes to requester 0.
- With RAM_ARB_FIXED_PRIO_EN: req[0] and req[1] held -> req[0] always wins; req[1] is granted only after req[0] drops.
